// File: rtl/sram_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : sram_bus_arbiter_if
// Description : Signal bundle around the fetch/data to single-bus arbiter.
//               inst_* : fetch requester (read-only, word)
//               data_* : data requester (read/write, byte/half/word)
//               bus_*  : shared sram-like bus toward the bus bridge
//               Split handshake: req/addr_ok for the address phase,
//               data_ok/rdata for the in-order response phase.
//               modport master : arbiter side
//               modport slave  : requesters + bus bridge side
// Revision    : 1.0 - initial release
// ============================================================================
interface sram_bus_arbiter_if #(
    parameter int ADDR_W = 32
) ();
    // fetch requester
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_addr_ok;
    logic              inst_data_ok;
    logic [31:0]       inst_rdata;
    // data requester
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [31:0]       data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [31:0]       data_rdata;
    // shared bus
    logic              bus_req;
    logic              bus_wr;
    logic [1:0]        bus_size;
    logic [3:0]        bus_wstrb;
    logic [ADDR_W-1:0] bus_addr;
    logic [31:0]       bus_wdata;
    logic              bus_addr_ok;
    logic              bus_data_ok;
    logic [31:0]       bus_rdata;

    modport master (
        input  inst_req, inst_addr,
        input  data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        input  bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_addr_ok, inst_data_ok, inst_rdata,
        output data_addr_ok, data_data_ok, data_rdata,
        output bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata
    );

    modport slave (
        output inst_req, inst_addr,
        output data_req, data_wr, data_size, data_wstrb, data_addr, data_wdata,
        output bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_addr_ok, inst_data_ok, inst_rdata,
        input  data_addr_ok, data_data_ok, data_rdata,
        input  bus_req, bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata
    );
endinterface
`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_bus_arbiter
// Description : Shares one sram-like bus between the fetch stage and the
//               memory stage. A grant is held stable across a stalled
//               address handshake, and an in-order ID FIFO steers each
//               response back to the requester that issued it.
// Ports       : clk, reset   - clock, synchronous active-high reset
//               arb          - sram_bus_arbiter_if.master (inst_*, data_*,
//                              bus_* handshake groups)
//               proto_err    - sticky: bus_data_ok with nothing outstanding
// Options     : `define ARB_ROUND_ROBIN_EN  -> alternate grants on contention
//               (default: fixed priority, data over inst)
// Revision    : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter #(
    parameter int MAX_OUTST = 4,
    parameter int ADDR_W    = 32
) (
    input  wire logic               clk,
    input  wire logic               reset,
    sram_bus_arbiter_if.master      arb,
    output logic                    proto_err
);
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;
    localparam logic SEL_INST = 1'b0;
    localparam logic SEL_DATA = 1'b1;
    localparam logic [CNT_W-1:0] C_FULL = CNT_W'(MAX_OUTST);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    state_t               r_state;
    logic                 r_lock_sel;
    logic [MAX_OUTST-1:0] r_fifo;
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic                 r_proto_err;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_pick;
    logic                 w_sel;
    logic                 w_bus_req;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_head;
    logic                 w_bus_wr;
    logic [1:0]           w_bus_size;
    logic [3:0]           w_bus_wstrb;
    logic [ADDR_W-1:0]    w_bus_addr;
    logic [31:0]          w_bus_wdata;

    // Full is judged on the registered count, so a pop in the same cycle
    // does not open a new grant.
    assign w_full  = (r_count == C_FULL);
    assign w_empty = (r_count == '0);

`ifdef ARB_ROUND_ROBIN_EN
    logic r_last_grant;
    assign w_pick = (arb.inst_req && arb.data_req) ? ~r_last_grant : arb.data_req;
`else
    assign w_pick = arb.data_req;
`endif

    // Grant selection. While locked the bus follows the locked requester's
    // req as-is, even if a higher-priority request shows up.
    always_comb begin
        w_sel     = w_pick;
        w_bus_req = 1'b0;
        if (r_state == ST_LOCK) begin
            w_sel     = r_lock_sel;
            w_bus_req = r_lock_sel ? arb.data_req : arb.inst_req;
        end else begin
            w_bus_req = !w_full && (arb.inst_req || arb.data_req);
        end
        if (reset) begin
            w_bus_req = 1'b0;
        end
    end

    // Bus fields are zero whenever no request is driven.
    always_comb begin
        w_bus_wr    = 1'b0;
        w_bus_size  = 2'd0;
        w_bus_wstrb = 4'd0;
        w_bus_addr  = '0;
        w_bus_wdata = 32'd0;
        if (w_bus_req) begin
            if (w_sel == SEL_DATA) begin
                w_bus_wr    = arb.data_wr;
                w_bus_size  = arb.data_size;
                w_bus_wstrb = arb.data_wstrb;
                w_bus_addr  = arb.data_addr;
                w_bus_wdata = arb.data_wdata;
            end else begin
                w_bus_size  = 2'd2;
                w_bus_addr  = arb.inst_addr;
            end
        end
    end

    assign arb.bus_req   = w_bus_req;
    assign arb.bus_wr    = w_bus_wr;
    assign arb.bus_size  = w_bus_size;
    assign arb.bus_wstrb = w_bus_wstrb;
    assign arb.bus_addr  = w_bus_addr;
    assign arb.bus_wdata = w_bus_wdata;

    assign w_push = w_bus_req && arb.bus_addr_ok;
    assign w_pop  = arb.bus_data_ok && !w_empty && !reset;
    assign w_head = r_fifo[r_rd_ptr];

    assign arb.inst_addr_ok = w_push && (w_sel == SEL_INST);
    assign arb.data_addr_ok = w_push && (w_sel == SEL_DATA);
    assign arb.inst_data_ok = w_pop && (w_head == SEL_INST);
    assign arb.data_data_ok = w_pop && (w_head == SEL_DATA);
    assign arb.inst_rdata   = arb.bus_rdata;
    assign arb.data_rdata   = arb.bus_rdata;
    assign proto_err        = r_proto_err && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_lock_sel  <= SEL_INST;
            r_fifo      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_proto_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            r_last_grant <= SEL_INST;
`endif
        end else begin
            if (r_state == ST_IDLE) begin
                if (w_bus_req && !arb.bus_addr_ok) begin
                    r_state    <= ST_LOCK;
                    r_lock_sel <= w_sel;
                end
            end else if (arb.bus_addr_ok) begin
                r_state <= ST_IDLE;
            end

            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_sel;
                r_wr_ptr         <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_count <= r_count - CNT_W'(1);
            end

            if (arb.bus_data_ok && w_empty) begin
                r_proto_err <= 1'b1;
            end
`ifdef ARB_ROUND_ROBIN_EN
            if (w_push) begin
                r_last_grant <= w_sel;
            end
`endif
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sram_bus_arbiter
// Description : Self-checking bench for sram_bus_arbiter. A transaction-level
//               model (pending grant owner + queue of outstanding owners)
//               predicts every output each cycle; directed sequences pin
//               key values with literal expectations, followed by a
//               randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;
    localparam int MAXO = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic proto_err;

    sram_bus_arbiter_if #(.ADDR_W(32)) sif ();

    sram_bus_arbiter #(.MAX_OUTST(MAXO), .ADDR_W(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .arb       (sif),
        .proto_err (proto_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model state
    bit mq[$];          // owners of accepted, unanswered transactions (1=data)
    bit m_pend;         // a grant was given and its address is not yet accepted
    bit m_pend_owner;
    bit m_proto;
    bit m_last;

    // expectations for the current cycle
    bit e_breq, e_owner, e_iaok, e_daok, e_idok, e_ddok, e_pop;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    task automatic clr_in();
        sif.inst_req = 0; sif.inst_addr = 32'h1c000000;
        sif.data_req = 0; sif.data_wr = 0; sif.data_size = 2'd2; sif.data_wstrb = 4'h0;
        sif.data_addr = 32'h0; sif.data_wdata = 32'h0;
        sif.bus_addr_ok = 0; sif.bus_data_ok = 0; sif.bus_rdata = 32'h0;
    endtask

    // compute expected outputs from the model and compare all of them
    task automatic eval();
        bit        e_wr;
        bit [1:0]  e_size;
        bit [3:0]  e_wstrb;
        bit [31:0] e_addr, e_wdata;
        #1;
        e_breq = 0; e_owner = 0;
        if (!reset) begin
            if (m_pend) begin
                e_owner = m_pend_owner;
                e_breq  = m_pend_owner ? sif.data_req : sif.inst_req;
            end else if (mq.size() < MAXO && (sif.inst_req || sif.data_req)) begin
                e_breq = 1;
`ifdef ARB_ROUND_ROBIN_EN
                if (sif.inst_req && sif.data_req) e_owner = !m_last;
                else e_owner = sif.data_req;
`else
                e_owner = sif.data_req;
`endif
            end
        end
        e_wr = 0; e_size = 0; e_wstrb = 0; e_addr = 0; e_wdata = 0;
        if (e_breq) begin
            if (e_owner) begin
                e_wr = sif.data_wr; e_size = sif.data_size; e_wstrb = sif.data_wstrb;
                e_addr = sif.data_addr; e_wdata = sif.data_wdata;
            end else begin
                e_size = 2'd2; e_addr = sif.inst_addr;
            end
        end
        e_iaok = e_breq && sif.bus_addr_ok && !e_owner;
        e_daok = e_breq && sif.bus_addr_ok &&  e_owner;
        e_pop  = !reset && sif.bus_data_ok && mq.size() > 0;
        e_idok = e_pop && (mq[0] == 1'b0);
        e_ddok = e_pop && (mq[0] == 1'b1);

        chk("bus_req",      sif.bus_req,      e_breq);
        chk("bus_wr",       sif.bus_wr,       e_wr);
        chk("bus_size",     sif.bus_size,     e_size);
        chk("bus_wstrb",    sif.bus_wstrb,    e_wstrb);
        chk("bus_addr",     sif.bus_addr,     e_addr);
        chk("bus_wdata",    sif.bus_wdata,    e_wdata);
        chk("inst_addr_ok", sif.inst_addr_ok, e_iaok);
        chk("data_addr_ok", sif.data_addr_ok, e_daok);
        chk("inst_data_ok", sif.inst_data_ok, e_idok);
        chk("data_data_ok", sif.data_data_ok, e_ddok);
        chk("inst_rdata",   sif.inst_rdata,   sif.bus_rdata);
        chk("data_rdata",   sif.data_rdata,   sif.bus_rdata);
        chk("proto_err",    proto_err,        !reset && m_proto);
    endtask

    // advance the model across the clock edge
    task automatic tick();
        @(posedge clk);
        if (reset) begin
            mq.delete(); m_pend = 0; m_pend_owner = 0; m_proto = 0; m_last = 0;
        end else begin
            if (sif.bus_data_ok && mq.size() == 0) m_proto = 1;
            if (e_pop) void'(mq.pop_front());
            if (e_breq && sif.bus_addr_ok) begin
                mq.push_back(e_owner);
                m_last = e_owner;
            end
            if (sif.bus_addr_ok) m_pend = 0;
            else if (e_breq) begin m_pend = 1; m_pend_owner = e_owner; end
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic step();
        eval();
        tick();
    endtask

    initial begin
        clr_in();
        reset = 1;

        // ---------------- reset with a pending fetch ----------------
        sif.inst_req = 1; sif.inst_addr = 32'h1c000000;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("rst_bus_req", sif.bus_req, 0);
            chk("rst_inst_addr_ok", sif.inst_addr_ok, 0);
            chk("rst_proto_err", proto_err, 0);
            tick();
        end
        reset = 0;
        sif.bus_addr_ok = 1;
        eval();
        chk("first_bus_req", sif.bus_req, 1);
        chk("first_bus_addr", sif.bus_addr, 32'h1c000000);
        chk("first_inst_addr_ok", sif.inst_addr_ok, 1);
        tick();
        sif.inst_req = 0; sif.bus_addr_ok = 0; sif.bus_data_ok = 1; sif.bus_rdata = 32'h11;
        eval();
        chk("first_inst_data_ok", sif.inst_data_ok, 1);
        chk("first_inst_rdata", sif.inst_rdata, 32'h11);
        tick();
        sif.bus_data_ok = 0;

        // ---------------- contention, addr_ok delayed ----------------
        sif.inst_req = 1; sif.inst_addr = 32'h1c000000;
        sif.data_req = 1; sif.data_wr = 1; sif.data_size = 2'd2; sif.data_wstrb = 4'hF;
        sif.data_addr = 32'h1c001000; sif.data_wdata = 32'hDEADBEEF;
        for (int i = 0; i < 3; i++) begin
            sif.bus_addr_ok = (i == 2);
            eval();
            chk("cont_bus_addr", sif.bus_addr, 32'h1c001000);
            chk("cont_bus_wr", sif.bus_wr, 1);
            chk("cont_data_addr_ok", sif.data_addr_ok, (i == 2));
            tick();
        end
        // second contention: new data write while inst still waiting
        sif.data_addr = 32'h1c001004;
        eval();
`ifdef ARB_ROUND_ROBIN_EN
        chk("cont2_bus_addr", sif.bus_addr, 32'h1c000000);
        tick();
        sif.inst_req = 0;
        eval();
        chk("cont3_bus_addr", sif.bus_addr, 32'h1c001004);
        tick();
`else
        chk("cont2_bus_addr", sif.bus_addr, 32'h1c001004);
        tick();
        sif.data_req = 0;
        eval();
        chk("cont3_bus_addr", sif.bus_addr, 32'h1c000000);
        tick();
`endif
        sif.inst_req = 0; sif.data_req = 0; sif.bus_addr_ok = 0; sif.bus_data_ok = 1;
        sif.bus_rdata = 32'h1;
        eval();
        chk("cont_first_resp_data", sif.data_data_ok, 1);
        tick();
        for (int i = 0; i < 2; i++) begin
            sif.bus_rdata = 32'h2 + i;
            step();
        end
        sif.bus_data_ok = 0;

        // ---------------- lock ----------------
        sif.inst_req = 1; sif.inst_addr = 32'h1c000010;
        step();
        sif.data_req = 1; sif.data_wr = 0; sif.data_wstrb = 4'h0; sif.data_addr = 32'h1c002000;
        eval();
        chk("lock_bus_addr", sif.bus_addr, 32'h1c000010);
        tick();
        sif.bus_addr_ok = 1;
        eval();
        chk("lock_inst_addr_ok", sif.inst_addr_ok, 1);
        chk("lock_data_addr_ok", sif.data_addr_ok, 0);
        tick();
        sif.inst_req = 0;
        eval();
        chk("lock_after_bus_addr", sif.bus_addr, 32'h1c002000);
        chk("lock_after_data_addr_ok", sif.data_addr_ok, 1);
        tick();
        sif.data_req = 0; sif.bus_addr_ok = 0; sif.bus_data_ok = 1; sif.bus_rdata = 32'hA;
        eval();
        chk("lock_resp0_inst", sif.inst_data_ok, 1);
        tick();
        sif.bus_rdata = 32'hB;
        eval();
        chk("lock_resp1_data", sif.data_data_ok, 1);
        chk("lock_resp1_rdata", sif.data_rdata, 32'hB);
        tick();
        sif.bus_data_ok = 0;

        // ---------------- full FIFO ----------------
        sif.inst_req = 1; sif.bus_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            sif.inst_addr = 32'h1c000000 + 32'(4 * i);
            step();
        end
        sif.inst_addr = 32'h1c000100;
        eval();
        chk("full_bus_req", sif.bus_req, 0);
        tick();
        sif.bus_data_ok = 1; sif.bus_rdata = 32'h55;
        eval();
        chk("full_pop_inst_data_ok", sif.inst_data_ok, 1);
        chk("full_pop_bus_req", sif.bus_req, 0);
        tick();
        sif.bus_data_ok = 0;
        eval();
        chk("full_reopen_bus_req", sif.bus_req, 1);
        tick();
        sif.inst_req = 0; sif.bus_addr_ok = 0; sif.bus_data_ok = 1;
        for (int i = 0; i < 4; i++) step();
        sif.bus_data_ok = 0;

        // ---------------- ordering with overlapping handshakes ----------------
        sif.inst_req = 1; sif.inst_addr = 32'h1c000000; sif.bus_addr_ok = 1;
        step();
        sif.inst_req = 0; sif.data_req = 1; sif.data_wr = 0; sif.data_addr = 32'h1c002000;
        sif.bus_data_ok = 1; sif.bus_rdata = 32'hA;
        eval();
        chk("ord_a_inst_data_ok", sif.inst_data_ok, 1);
        chk("ord_a_rdata", sif.inst_rdata, 32'hA);
        chk("ord_a_data_addr_ok", sif.data_addr_ok, 1);
        tick();
        sif.data_req = 0; sif.inst_req = 1; sif.inst_addr = 32'h1c000004; sif.bus_rdata = 32'hB;
        eval();
        chk("ord_b_data_data_ok", sif.data_data_ok, 1);
        chk("ord_b_inst_data_ok", sif.inst_data_ok, 0);
        tick();
        sif.inst_req = 0; sif.bus_addr_ok = 0; sif.bus_rdata = 32'hC;
        eval();
        chk("ord_c_inst_data_ok", sif.inst_data_ok, 1);
        chk("ord_c_rdata", sif.inst_rdata, 32'hC);
        tick();
        sif.bus_data_ok = 0;

        // ---------------- randomized traffic ----------------
        for (int n = 0; n < 4000; n++) begin
            bit slow_resp;
            slow_resp = ((n / 400) % 2) == 1;
            if (!(sif.inst_req && !e_iaok)) begin
                sif.inst_req  = ($urandom_range(0, 3) != 0);
                sif.inst_addr = 32'h1c000000 | ($urandom & 32'h0000FFFC);
            end
            if (!(sif.data_req && !e_daok)) begin
                sif.data_req   = ($urandom_range(0, 2) != 0);
                sif.data_wr    = $urandom_range(0, 1);
                sif.data_size  = 2'($urandom_range(0, 2));
                sif.data_wstrb = 4'($urandom);
                sif.data_addr  = 32'h1c000000 | ($urandom & 32'h0000FFFF);
                sif.data_wdata = $urandom;
            end
            sif.bus_addr_ok = ($urandom_range(0, 2) != 0);
            sif.bus_data_ok = (mq.size() > 0) &&
                              (slow_resp ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 2) != 0));
            sif.bus_rdata   = $urandom;
            step();
        end

        // ---------------- protocol error ----------------
        clr_in();
        reset = 1;
        step();
        reset = 0;
        sif.bus_data_ok = 1; sif.bus_rdata = 32'h77;
        eval();
        chk("perr_inst_data_ok", sif.inst_data_ok, 0);
        chk("perr_data_data_ok", sif.data_data_ok, 0);
        chk("perr_same_cycle", proto_err, 0);
        tick();
        sif.bus_data_ok = 0;
        for (int i = 0; i < 3; i++) begin
            eval();
            chk("perr_sticky", proto_err, 1);
            tick();
        end
        reset = 1;
        step();
        reset = 0;
        eval();
        chk("perr_cleared", proto_err, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
